spi_req_arbiter: RTL and testbench
==================================

Name: spi_req_arbiter

Overview:
- Shares one spi_master among N_REQ requesters (e.g. config FSMs, sensor pollers).
- Round-robin arbitration; latches the winner's byte, mode and divider, then pulses spi_master start.
- Waits for the master's done, returns received byte plus per-requester completion pulse.
- Sits between requester logic and the spi_master inputs (start, tdat, mlb, cdiv) and outputs (done, rdata).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, SPI word width; matches spi_master tdat/rdata.
- START_CYC, 2, clk cycles m_start is held high per transaction (1..15).
- TO_CYC, 4096, watchdog limit in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until own rdone.
- req_tdat  in  N_REQ*DW  flattened tx bytes; requester i at [i*DW +: DW].
- req_mlb  in  N_REQ  per-requester bit order; same meaning as spi_master mlb.
- req_cdiv  in  2*N_REQ  per-requester clock divider; requester i at [2i +: 2].
- gnt  out  N_REQ  one-hot grant, high from capture to end of DONE.
- rdone  out  N_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  DW  received byte; valid in the rdone cycle, held until the next capture.
- busy  out  1  high whenever state != IDLE.
- m_start  out  1  to spi_master start.
- m_tdat  out  DW  to spi_master tdat.
- m_mlb  out  1  to spi_master mlb.
- m_cdiv  out  2  to spi_master cdiv.
- m_done  in  1  from spi_master done.
- m_rdata  in  DW  from spi_master rdata.
- timeout  out  1  sticky error flag; only with SPI_ARB_TIMEOUT_EN, otherwise tied 0.

Behaviour:
- Reset: state IDLE. gnt, rdone, rdata, m_start, m_tdat, m_mlb, m_cdiv, busy and timeout all 0. Round-robin pointer last = N_REQ-1, so requester 0 wins first. Reset mid-transaction aborts at that edge: m_start drops and no rdone is issued.
- FSM has four states: IDLE, START, WAIT, DONE.
- IDLE:
  - If |req, pick the first set bit scanning from last+1 upward with wrap-around.
  - Capture that requester's tdat, mlb and cdiv into m_tdat, m_mlb and m_cdiv.
  - Set gnt[idx] and go to START. Latency from req to m_start high is 1 cycle.
- START: m_start=1 for START_CYC cycles (counter), then m_start=0 and go to WAIT. m_tdat, m_mlb and m_cdiv stay stable for the whole transaction.
- WAIT:
  - Completion is a rising edge of m_done (m_done_q registered, reset 0). A done level already high on entry is ignored.
  - On the edge, rdata <= m_rdata and go to DONE.
- DONE: rdone[idx]=1 for one cycle; last <= idx; gnt clears when the state returns to IDLE on the next edge. A new arbitration can start in the cycle after DONE.
- Fairness: a requester that re-asserts immediately cannot win twice while another req is pending.
- A req drop while granted does not abort. The transaction completes and rdone still pulses; the requester may ignore it.
- req bits changing outside IDLE have no effect until the next IDLE sample.
- With a single pending requester, back-to-back grants to the same index are allowed.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in START+WAIT and clears on each capture.
  - Reaching TO_CYC forces DONE with rdata=8'hFF (all ones, DW wide) and sets timeout=1.
  - timeout clears only on rst.
- Without the macro: no counter, WAIT lasts indefinitely, timeout tied 0.

Decomposition:
- Package spi_arb_pkg holds:
  - state encoding (ST_IDLE=2'd0, ST_START=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3);
  - IDX_W = clog2(N_REQ);
  - TIMEOUT_DATA constant (all ones).
- One sub-module, spi_rr_pick: combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: idx, valid.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request: req=4'b0001, tdat0=8'h7C, mlb0=0, cdiv0=0 -> m_start high 2 cycles with m_tdat=8'h7C; the SPI slave echo returns 8'hAA -> rdone=4'b0001 once, rdata=8'hAA, busy falls the cycle after.
- Contention: req=4'b1010 held -> grant order 1,3,1,3; no requester is granted twice in a row.
- Captured config: requester 2 with mlb=1, cdiv=2'b01, tdat=8'h1C -> m_mlb=1, m_cdiv=1, m_tdat=8'h1C for the whole transaction, even if req_tdat changes to 8'hE3 mid-WAIT.
- Req withdrawal: req0 dropped during WAIT -> the transaction still completes and rdone[0] pulses.
- Reset mid-WAIT: rst=1 for 1 cycle -> next cycle all outputs 0 and state IDLE; a later m_done edge produces no rdone.
- SPI_ARB_TIMEOUT_EN, TO_CYC=64, m_done held 0 -> rdone pulses after 64 cycles with rdata=8'hFF and timeout=1, which stays set until rst.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI request arbiter slice.
//   - State encoding for the arbiter FSM.
//   - Default sizing (requesters, word width) and the index width derived from it.
//   - Data word returned to a requester when a transaction is abandoned by the watchdog.
// Optional feature macro used by the arbiter: SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 8;

  // Width needed to index n requesters (never below 1 bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = idx_w(DEF_N_REQ);

  // All-ones word handed back on a watchdog abort.
  localparam logic [DEF_DW-1:0] TIMEOUT_DATA = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester-side and spi_master-side signals around the arbiter.
//   slave  : arbiter view (takes requests and master results, drives grants and master controls)
//   master : surrounding logic view (requesters plus the spi_master)
// Requester i owns req[i], req_tdat[i*DW +: DW], req_mlb[i], req_cdiv[2i +: 2].
interface spi_req_arbiter_if #(
  parameter int N_REQ = spi_arb_pkg::DEF_N_REQ,
  parameter int DW    = spi_arb_pkg::DEF_DW
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_tdat;
  logic [N_REQ-1:0]    req_mlb;
  logic [2*N_REQ-1:0]  req_cdiv;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rdone;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic                m_start;
  logic [DW-1:0]       m_tdat;
  logic                m_mlb;
  logic [1:0]          m_cdiv;
  logic                m_done;
  logic [DW-1:0]       m_rdata;
  logic                timeout;

  modport slave (
    input  req, req_tdat, req_mlb, req_cdiv, m_done, m_rdata,
    output gnt, rdone, rdata, busy, m_start, m_tdat, m_mlb, m_cdiv, timeout
  );

  modport master (
    output req, req_tdat, req_mlb, req_cdiv, m_done, m_rdata,
    input  gnt, rdone, rdata, busy, m_start, m_tdat, m_mlb, m_cdiv, timeout
  );
endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : index served most recently
//   idx   : first set request scanning upward from last+1 with wrap-around
//   valid : any request set
module spi_rr_pick #(
  parameter int N_REQ = spi_arb_pkg::DEF_N_REQ,
  parameter int IDX_W = spi_arb_pkg::IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan offsets from farthest to nearest so the nearest hit is the final write.
  always_comb begin
    int pos;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = (int'(last) + k) % N_REQ;
      if (req[pos]) begin
        idx   = IDX_W'(pos);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master among N_REQ requesters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : spi_req_arbiter_if.slave (requests/grants/results and spi_master controls)
// The winner's byte, bit order and divider are latched at grant and held for the
// whole transaction; completion is the rising edge of m_done while waiting.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort transactions after TO_CYC
// cycles in START+WAIT, returning all-ones data and setting a sticky timeout flag.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DW        = DEF_DW,
  parameter int START_CYC = 2,
  parameter int TO_CYC    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  spi_req_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rdone_q, rdone_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             m_start_q, m_start_d;
  logic [DW-1:0]    m_tdat_q, m_tdat_d;
  logic             m_mlb_q, m_mlb_d;
  logic [1:0]       m_cdiv_q, m_cdiv_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [3:0]       start_cnt_q, start_cnt_d;
  logic             m_done_q;
  logic             done_rise;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  spi_rr_pick #(.N_REQ(N_REQ), .IDX_W(IW)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign done_rise = bus.m_done & ~m_done_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = TO_CYC;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rdone_d     = '0;
    rdata_d     = rdata_q;
    m_start_d   = m_start_q;
    m_tdat_d    = m_tdat_q;
    m_mlb_d     = m_mlb_q;
    m_cdiv_d    = m_cdiv_q;
    idx_d       = idx_q;
    last_d      = last_q;
    start_cnt_d = start_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          idx_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          m_tdat_d        = bus.req_tdat[int'(pick_idx)*DW +: DW];
          m_mlb_d         = bus.req_mlb[pick_idx];
          m_cdiv_d        = bus.req_cdiv[2*int'(pick_idx) +: 2];
          m_start_d       = 1'b1;
          start_cnt_d     = '0;
          state_d         = ST_START;
        end
      end
      ST_START: begin
        if (start_cnt_q == 4'(START_CYC - 1)) begin
          m_start_d = 1'b0;
          state_d   = ST_WAIT;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (done_rise) begin
          rdata_d = bus.m_rdata;
          rdone_d = gnt_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = idx_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (state_q == ST_IDLE && pick_valid) begin
      to_cnt_d = '0;
    end else if (state_q == ST_START || state_q == ST_WAIT) begin
      // Watchdog wins over a coincident done edge.
      if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
        state_d   = ST_DONE;
        rdata_d   = {DW{TIMEOUT_DATA[0]}};
        rdone_d   = gnt_q;
        m_start_d = 1'b0;
        timeout_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rdone_q     <= '0;
      rdata_q     <= '0;
      m_start_q   <= 1'b0;
      m_tdat_q    <= '0;
      m_mlb_q     <= 1'b0;
      m_cdiv_q    <= '0;
      idx_q       <= '0;
      last_q      <= IW'(N_REQ - 1);
      start_cnt_q <= '0;
      m_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rdone_q     <= rdone_d;
      rdata_q     <= rdata_d;
      m_start_q   <= m_start_d;
      m_tdat_q    <= m_tdat_d;
      m_mlb_q     <= m_mlb_d;
      m_cdiv_q    <= m_cdiv_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      start_cnt_q <= start_cnt_d;
      m_done_q    <= bus.m_done;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.rdone   = rdone_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.m_start = m_start_q;
  assign bus.m_tdat  = m_tdat_q;
  assign bus.m_mlb   = m_mlb_q;
  assign bus.m_cdiv  = m_cdiv_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: a table of back-to-back transactions
// (grant order, captured config, returned data) plus hand sequences for
// done-level-on-entry, reset mid-WAIT and, when SPI_ARB_TIMEOUT_EN is defined,
// the watchdog abort.
module tb_spi_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_req_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

  spi_req_arbiter #(.N_REQ(N), .DW(DW), .START_CYC(2), .TO_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    int         act;      // 0 none, 1 change tdat mid-WAIT, 2 drop req mid-WAIT
    logic [7:0] srdata;   // byte the slave returns
    int         exp_idx;
    logic [7:0] exp_tdat;
    logic       exp_mlb;
    logic [1:0] exp_cdiv;
  } vec_t;

  vec_t tbl [11];

  localparam logic [31:0] TDAT_ALL = 32'hC61C357C;  // r3 C6, r2 1C, r1 35, r0 7C
  localparam logic [3:0]  MLB_ALL  = 4'b0100;
  localparam logic [7:0]  CDIV_ALL = 8'b10_01_11_00; // r3 2, r2 1, r1 3, r0 0

  task automatic wait_gnt(input string nm, output int n);
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_gnt_wait"}, 32'(n < 20), 32'd1);
  endtask

  task automatic wait_start_low(output int n);
    n = 0;
    while (bus.m_start && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input int i);
    int n;
    logic [3:0] nxt;
    wait_gnt("tbl", n);
    chk("req_to_gnt_latency", n, 1);
    chk("gnt", bus.gnt, 32'(4'b1 << tbl[i].exp_idx));
    chk("m_start_on_grant", bus.m_start, 1);
    chk("m_tdat", bus.m_tdat, tbl[i].exp_tdat);
    chk("m_mlb", bus.m_mlb, tbl[i].exp_mlb);
    chk("m_cdiv", bus.m_cdiv, tbl[i].exp_cdiv);
    wait_start_low(n);
    chk("start_cycles", n, 2);
    if (tbl[i].act == 1) bus.req_tdat[tbl[i].exp_idx*8 +: 8] = 8'hE3;
    if (tbl[i].act == 2) bus.req[tbl[i].exp_idx] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wait_hold_cfg", {bus.m_tdat, 7'd0, bus.m_mlb, 6'd0, bus.m_cdiv, 7'd0, bus.busy},
          {tbl[i].exp_tdat, 7'd0, tbl[i].exp_mlb, 6'd0, tbl[i].exp_cdiv, 7'd0, 1'b1});
    end
    bus.m_rdata = tbl[i].srdata;
    bus.m_done  = 1'b1;
    @(negedge clk);
    chk("rdone", bus.rdone, 32'(4'b1 << tbl[i].exp_idx));
    chk("rdata", bus.rdata, tbl[i].srdata);
    $display("txn %0d: req=%b gnt=%b rdone=%b rdata=%h", i, tbl[i].req, bus.gnt, bus.rdone, bus.rdata);
    nxt = (i + 1 < 11) ? tbl[i + 1].req : 4'b0;
    bus.m_done   = 1'b0;
    bus.req      = nxt;
    bus.req_tdat = TDAT_ALL;
    @(negedge clk);
    chk("idle_after_done", {bus.rdone, bus.gnt, 3'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    tbl[0]  = '{4'b0001, 0, 8'hAA, 0, 8'h7C, 1'b0, 2'd0};
    tbl[1]  = '{4'b1010, 0, 8'h11, 1, 8'h35, 1'b0, 2'd3};
    tbl[2]  = '{4'b1010, 0, 8'h22, 3, 8'hC6, 1'b0, 2'd2};
    tbl[3]  = '{4'b1010, 0, 8'h33, 1, 8'h35, 1'b0, 2'd3};
    tbl[4]  = '{4'b1010, 0, 8'h44, 3, 8'hC6, 1'b0, 2'd2};
    tbl[5]  = '{4'b1111, 0, 8'h55, 0, 8'h7C, 1'b0, 2'd0};
    tbl[6]  = '{4'b1111, 0, 8'h66, 1, 8'h35, 1'b0, 2'd3};
    tbl[7]  = '{4'b0100, 1, 8'h77, 2, 8'h1C, 1'b1, 2'd1};
    tbl[8]  = '{4'b0100, 0, 8'h88, 2, 8'h1C, 1'b1, 2'd1};
    tbl[9]  = '{4'b1001, 0, 8'h99, 3, 8'hC6, 1'b0, 2'd2};
    tbl[10] = '{4'b1001, 2, 8'hA5, 0, 8'h7C, 1'b0, 2'd0};

    bus.req      = '0;
    bus.req_tdat = TDAT_ALL;
    bus.req_mlb  = MLB_ALL;
    bus.req_cdiv = CDIV_ALL;
    bus.m_done   = 1'b0;
    bus.m_rdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rdone", bus.rdone, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_start", bus.m_start, 0);
    chk("rst_m_tdat", bus.m_tdat, 0);
    chk("rst_m_mlb_cdiv", {bus.m_mlb, bus.m_cdiv}, 0);
    chk("rst_timeout", bus.timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table: back-to-back transactions
    bus.req = tbl[0].req;
    for (int i = 0; i < 11; i++) run_txn(i);

    // Done level already high when WAIT is entered: must be ignored
    bus.m_done = 1'b1;
    bus.req    = 4'b0001;
    wait_gnt("lvl", n);
    chk("lvl_gnt", bus.gnt, 4'b0001);
    wait_start_low(n);
    repeat (4) begin
      @(negedge clk);
      chk("lvl_no_rdone", {bus.rdone, 3'd0, bus.busy}, 32'd1);
    end
    bus.m_done = 1'b0;
    @(negedge clk);
    bus.m_done  = 1'b1;
    bus.m_rdata = 8'h5A;
    @(negedge clk);
    chk("lvl_rdone", bus.rdone, 4'b0001);
    chk("lvl_rdata", bus.rdata, 8'h5A);
    $display("txn lvl: rdone=%b rdata=%h", bus.rdone, bus.rdata);
    bus.m_done = 1'b0;
    bus.req    = '0;
    @(negedge clk);

    // Reset mid-WAIT aborts; later done edge gives no rdone
    bus.req = 4'b0010;
    wait_gnt("rstw", n);
    chk("rstw_gnt", bus.gnt, 4'b0010);
    wait_start_low(n);
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_outputs", {bus.gnt, bus.rdone, bus.rdata, 7'd0, bus.busy},
        32'd0);
    chk("rstw_master", {bus.m_tdat, 5'd0, bus.m_start, bus.m_mlb, bus.m_cdiv}, 32'd0);
    bus.m_rdata = 8'hC3;
    bus.m_done  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstw_no_rdone", {bus.rdone, 3'd0, bus.busy}, 32'd0);
    end
    bus.m_done = 1'b0;
    $display("txn rstw: aborted, rdone=%b", bus.rdone);
    // Pointer restored: requester 0 wins among all four
    bus.req = 4'b1111;
    wait_gnt("post_rst", n);
    chk("post_rst_gnt", bus.gnt, 4'b0001);
    wait_start_low(n);
    bus.m_rdata = 8'h3C;
    bus.m_done  = 1'b1;
    @(negedge clk);
    chk("post_rst_rdone", bus.rdone, 4'b0001);
    chk("post_rst_rdata", bus.rdata, 8'h3C);
    $display("txn post_rst: rdone=%b rdata=%h", bus.rdone, bus.rdata);
    bus.m_done = 1'b0;
    bus.req    = '0;
    @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    bus.req = 4'b0100;
    wait_gnt("to", n);
    n = 0;
    while (bus.rdone == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 64);
    chk("to_rdone", bus.rdone, 4'b0100);
    chk("to_rdata", bus.rdata, 8'hFF);
    chk("to_flag", bus.timeout, 1);
    $display("txn to: cycles=%0d rdone=%b rdata=%h timeout=%b", n, bus.rdone, bus.rdata, bus.timeout);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("to_sticky", bus.timeout, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("to_cleared", bus.timeout, 0);
`else
    chk("timeout_tied", bus.timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

endmodule
